// File: rtl/vga_sprite_painter.sv
// Pixel-colour stage behind the VGA timer: dino sprite, obstacle, ground and sky in a 2-cycle pipeline.
// Define VGA_COLLISION_EN to build the per-frame dino/obstacle collision flag.
module vga_sprite_painter #(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int OBST_W   = 12,
    parameter int OBST_H   = 24,
    parameter int GROUND_Y = 400,
    parameter int LATCH_Y  = 480
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 hsync_i,
    input  logic                                 vsync_i,
    input  logic                                 visible_i,
    input  logic [9:0]                           position_x_i,
    input  logic [9:0]                           position_y_i,
    input  logic [9:0]                           dino_x_i,
    input  logic [9:0]                           dino_y_i,
    input  logic [9:0]                           obst_x_i,
    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0] rom_addr_o,
    input  logic                                 rom_data_i,
    output logic [3:0]                           vga_red_o,
    output logic [3:0]                           vga_green_o,
    output logic [3:0]                           vga_blue_o,
    output logic                                 hsync_o,
    output logic                                 vsync_o,
    output logic                                 frame_start_o,
    output logic                                 collision_o
);

    localparam int LW = $clog2(SPRITE_W);
    localparam int LH = $clog2(SPRITE_H);

    localparam logic [11:0] COL_DINO   = 12'h333;
    localparam logic [11:0] COL_OBST   = 12'h0A0;
    localparam logic [11:0] COL_GROUND = 12'h850;
    localparam logic [11:0] COL_SKY    = 12'hFFF;

    // Shadow positions, only updated on the latch row so a frame never tears
    logic [9:0]  r_dino_x;
    logic [9:0]  r_dino_y;
    logic [9:0]  r_obst_x;
    logic        r_frame_start;

    logic        w_latch;
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic [10:0] w_dx0;
    logic [10:0] w_dx1;
    logic [10:0] w_dy0;
    logic [10:0] w_dy1;
    logic [10:0] w_ox0;
    logic [10:0] w_ox1;
    logic        w_dino_hit;
    logic        w_obst_hit;
    logic        w_ground;
    logic [LW-1:0] w_off_x;
    logic [LH-1:0] w_off_y;
    logic [11:0] w_fallback;

    logic        r_s1_dino;
    logic        r_s1_vis;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic [11:0] r_s1_fallback;
    logic [LH+LW-1:0] r_rom_addr;

    logic [11:0] r_rgb;
    logic        r_hs;
    logic        r_vs;

    assign w_latch = (position_x_i == 10'd0) && (position_y_i == 10'(LATCH_Y));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dino_x      <= '0;
            r_dino_y      <= '0;
            r_obst_x      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_latch;
            if (w_latch) begin
                r_dino_x <= dino_x_i;
                r_dino_y <= dino_y_i;
                r_obst_x <= obst_x_i;
            end
        end
    end

    // 11-bit compares so a sprite near column 1023 cannot wrap back to 0
    assign w_px  = {1'b0, position_x_i};
    assign w_py  = {1'b0, position_y_i};
    assign w_dx0 = {1'b0, r_dino_x};
    assign w_dx1 = w_dx0 + 11'(SPRITE_W);
    assign w_dy0 = {1'b0, r_dino_y};
    assign w_dy1 = w_dy0 + 11'(SPRITE_H);
    assign w_ox0 = {1'b0, r_obst_x};
    assign w_ox1 = w_ox0 + 11'(OBST_W);

    assign w_dino_hit = visible_i && (w_px >= w_dx0) && (w_px < w_dx1)
                                  && (w_py >= w_dy0) && (w_py < w_dy1);
    assign w_obst_hit = visible_i && (w_px >= w_ox0) && (w_px < w_ox1)
                                  && (w_py >= 11'(GROUND_Y - OBST_H)) && (w_py < 11'(GROUND_Y));
    assign w_ground   = (w_py >= 11'(GROUND_Y));

    assign w_off_x = LW'(position_x_i - r_dino_x);
    assign w_off_y = LH'(position_y_i - r_dino_y);

    always_comb begin
        w_fallback = COL_SKY;
        if (w_obst_hit) begin
            w_fallback = COL_OBST;
        end else if (w_ground) begin
            w_fallback = COL_GROUND;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_dino     <= 1'b0;
            r_s1_vis      <= 1'b0;
            r_s1_hs       <= 1'b1;
            r_s1_vs       <= 1'b1;
            r_s1_fallback <= '0;
            r_rom_addr    <= '0;
        end else begin
            r_s1_dino     <= w_dino_hit;
            r_s1_vis      <= visible_i;
            r_s1_hs       <= hsync_i;
            r_s1_vs       <= vsync_i;
            r_s1_fallback <= w_fallback;
            r_rom_addr    <= w_dino_hit ? {w_off_y, w_off_x} : '0;
        end
    end

    // ROM data for the stage-1 address is valid during this cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rgb <= '0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            r_hs <= r_s1_hs;
            r_vs <= r_s1_vs;
            if (!r_s1_vis) begin
                r_rgb <= '0;
            end else if (r_s1_dino && rom_data_i) begin
                r_rgb <= COL_DINO;
            end else begin
                r_rgb <= r_s1_fallback;
            end
        end
    end

`ifdef VGA_COLLISION_EN
    logic r_s1_obst;
    logic r_coll_flag;
    logic r_coll;
    logic w_coll_px;

    assign w_coll_px = r_s1_vis && r_s1_dino && rom_data_i && r_s1_obst;

    // A hit on the latch cycle itself belongs to the frame being started
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_obst   <= 1'b0;
            r_coll_flag <= 1'b0;
            r_coll      <= 1'b0;
        end else begin
            r_s1_obst <= w_obst_hit;
            if (w_latch) begin
                r_coll      <= r_coll_flag;
                r_coll_flag <= w_coll_px;
            end else begin
                r_coll_flag <= r_coll_flag | w_coll_px;
            end
        end
    end

    assign collision_o = r_coll;
`else
    assign collision_o = 1'b0;
`endif

    assign rom_addr_o    = r_rom_addr;
    assign vga_red_o     = r_rgb[11:8];
    assign vga_green_o   = r_rgb[7:4];
    assign vga_blue_o    = r_rgb[3:0];
    assign hsync_o       = r_hs;
    assign vsync_o       = r_vs;
    assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_vga_sprite_painter.sv
// Bench for vga_sprite_painter: timer positions are driven freely and every output is
// checked against a pixel-level picture model (collision model follows VGA_COLLISION_EN).
module tb_vga_sprite_painter;

    localparam int SW = 16;
    localparam int SH = 16;
    localparam int OW = 12;
    localparam int OH = 24;
    localparam int GY = 400;
    localparam int LY = 480;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       hsync_i, vsync_i, visible_i;
    logic [9:0] position_x_i, position_y_i;
    logic [9:0] dino_x_i, dino_y_i, obst_x_i;
    logic [7:0] rom_addr_o;
    logic       rom_data_i;
    logic [3:0] vga_red_o, vga_green_o, vga_blue_o;
    logic       hsync_o, vsync_o, frame_start_o, collision_o;

    logic rom_mem [256];
    assign rom_data_i = rom_mem[rom_addr_o];

    always #20 clk_i = ~clk_i;

    vga_sprite_painter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .visible_i(visible_i),
        .position_x_i(position_x_i), .position_y_i(position_y_i),
        .dino_x_i(dino_x_i), .dino_y_i(dino_y_i), .obst_x_i(obst_x_i),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .vga_red_o(vga_red_o), .vga_green_o(vga_green_o), .vga_blue_o(vga_blue_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o),
        .frame_start_o(frame_start_o), .collision_o(collision_o)
    );

    int total = 0;
    int bad   = 0;

    // picture model state
    int sh_dx, sh_dy, sh_ox;
    bit m_flag, m_pend, m_out;
    logic [11:0] q_rgb[$];
    logic        q_hs[$], q_vs[$];
    int          q_x[$], q_y[$];

    // values published by tick()
    logic [11:0] e_rgb, g_rgb;
    logic        e_hs, g_hs, e_vs, g_vs, e_fs, g_fs, e_coll, g_coll;
    logic [7:0]  e_addr, g_addr;
    int          o_x, o_y;

    function automatic bit in_dino(int x, int y);
        return x < 640 && y < 480 && x >= sh_dx && x < sh_dx + SW && y >= sh_dy && y < sh_dy + SH;
    endfunction

    function automatic bit in_obst(int x, int y);
        return x < 640 && y < 480 && x >= sh_ox && x < sh_ox + OW && y >= GY - OH && y < GY;
    endfunction

    function automatic bit opaque(int x, int y);
        if (!in_dino(x, y)) return 1'b0;
        return rom_mem[(y - sh_dy) * SW + (x - sh_dx)];
    endfunction

    function automatic logic [11:0] model_rgb(int x, int y);
        if (!(x < 640 && y < 480)) return 12'h000;
        if (opaque(x, y))          return 12'h333;
        if (in_obst(x, y))         return 12'h0A0;
        if (y >= GY)               return 12'h850;
        return 12'hFFF;
    endfunction

    task automatic reset_model();
        q_rgb.delete(); q_hs.delete(); q_vs.delete(); q_x.delete(); q_y.delete();
        q_rgb.push_back(12'h000); q_hs.push_back(1'b1); q_vs.push_back(1'b1);
        q_x.push_back(-1); q_y.push_back(-1);
        sh_dx = 0; sh_dy = 0; sh_ox = 0;
        m_flag = 0; m_pend = 0; m_out = 0;
    endtask

    // drive one timer position at a negedge, return at the next negedge
    task automatic tick(input int x, input int y);
        bit lat;
        position_x_i = 10'(x);
        position_y_i = 10'(y);
        visible_i    = (x < 640 && y < 480);
        hsync_i      = !(x >= 656 && x <= 751);
        vsync_i      = !(y == 490 || y == 491);
        q_rgb.push_back(model_rgb(x, y));
        q_hs.push_back(hsync_i);
        q_vs.push_back(vsync_i);
        q_x.push_back(x);
        q_y.push_back(y);
        e_addr = in_dino(x, y) ? 8'((y - sh_dy) * SW + (x - sh_dx)) : 8'h00;
        lat = (x == 0 && y == LY);
        if (lat) begin
            m_out  = m_flag;
            m_flag = m_pend;
        end else begin
            m_flag = m_flag | m_pend;
        end
        m_pend = opaque(x, y) && in_obst(x, y);
        if (lat) begin
            sh_dx = int'(dino_x_i); sh_dy = int'(dino_y_i); sh_ox = int'(obst_x_i);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        e_rgb = q_rgb.pop_front();
        e_hs  = q_hs.pop_front();
        e_vs  = q_vs.pop_front();
        o_x   = q_x.pop_front();
        o_y   = q_y.pop_front();
        e_fs  = lat;
`ifdef VGA_COLLISION_EN
        e_coll = m_out;
`else
        e_coll = 1'b0;
`endif
        g_rgb  = {vga_red_o, vga_green_o, vga_blue_o};
        g_hs   = hsync_o;
        g_vs   = vsync_o;
        g_fs   = frame_start_o;
        g_coll = collision_o;
        g_addr = rom_addr_o;
    endtask

    task automatic set_rom(input int mode);
        tick(790, 520);
        for (int i = 0; i < 256; i++)
            rom_mem[i] = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) rom_mem[i] = 1'b0;
        rst_i = 1'b1;
        dino_x_i = 10'd0; dino_y_i = 10'd0; obst_x_i = 10'd0;
        position_x_i = 10'd0; position_y_i = 10'd0;
        visible_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        reset_model();
        tick(5, 5); tick(6, 5); tick(300, 5);
        total++;
        if (g_rgb !== 12'hFFF) begin bad++; $display("FAIL pre_reset_rgb got=%h exp=fff", g_rgb); end
        #5 rst_i = 1'b1;
        #1;
        total++;
        if (g_rgb === {vga_red_o, vga_green_o, vga_blue_o} && {vga_red_o, vga_green_o, vga_blue_o} !== 12'h000) begin
            bad++; $display("FAIL async_reset_rgb got=%h exp=000", {vga_red_o, vga_green_o, vga_blue_o});
        end
        total++;
        if ({hsync_o, vsync_o, frame_start_o, collision_o} !== 4'b1100) begin
            bad++; $display("FAIL async_reset_ctl got=%b exp=1100", {hsync_o, vsync_o, frame_start_o, collision_o});
        end
        total++;
        if (rom_addr_o !== 8'h00) begin bad++; $display("FAIL async_reset_addr got=%h exp=00", rom_addr_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        reset_model();
        tick(10, 10);
        total++;
        if (g_rgb !== 12'h000 || g_hs !== 1'b1 || g_fs !== 1'b0) begin
            bad++; $display("FAIL post_reset_first got=%h/%b/%b exp=000/1/0", g_rgb, g_hs, g_fs);
        end
        tick(10, 10);
        total++;
        if (g_rgb !== 12'hFFF || e_rgb !== 12'hFFF) begin
            bad++; $display("FAIL post_reset_sky got=%h exp=fff", g_rgb);
        end
    endtask

    task automatic test_sync();
        int lows = 0;
        for (int x = 640; x < 800; x++) begin
            tick(x, 100);
            if (g_hs === 1'b0) lows++;
            total++;
            if (g_hs !== e_hs || g_vs !== e_vs || g_rgb !== e_rgb) begin
                bad++; $display("FAIL hsync x=%0d got=%b%b/%h exp=%b%b/%h", o_x, g_hs, g_vs, g_rgb, e_hs, e_vs, e_rgb);
            end
        end
        total++;
        if (lows != 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", lows); end
        for (int y = 486; y < 496; y++) begin
            tick(700, y);
            total++;
            if (g_vs !== e_vs || g_hs !== e_hs) begin
                bad++; $display("FAIL vsync y=%0d got=%b exp=%b", o_y, g_vs, e_vs);
            end
        end
    endtask

    task automatic test_dino();
        set_rom(1);
        dino_x_i = 10'd100; dino_y_i = 10'd200; obst_x_i = 10'd600;
        tick(0, LY);
        total++;
        if (g_fs !== 1'b1) begin bad++; $display("FAIL frame_start_pulse got=%b exp=1", g_fs); end
        tick(1, LY);
        total++;
        if (g_fs !== 1'b0) begin bad++; $display("FAIL frame_start_width got=%b exp=0", g_fs); end
        for (int x = 98; x <= 118; x++) begin
            tick(x, 200);
            total++;
            if (g_rgb !== e_rgb || g_addr !== e_addr) begin
                bad++; $display("FAIL dino_row x=%0d got=%h/%h exp=%h/%h", o_x, g_rgb, g_addr, e_rgb, e_addr);
            end
            if (o_x == 99 || o_x == 116) begin
                total++;
                if (g_rgb !== 12'hFFF) begin bad++; $display("FAIL dino_edge x=%0d got=%h exp=fff", o_x, g_rgb); end
            end
            if (o_x == 100 || o_x == 115) begin
                total++;
                if (g_rgb !== 12'h333) begin bad++; $display("FAIL dino_body x=%0d got=%h exp=333", o_x, g_rgb); end
            end
        end
        tick(100, 200);
        total++;
        if (g_addr !== 8'h00) begin bad++; $display("FAIL rom_addr_first got=%h exp=00", g_addr); end
        tick(115, 215);
        total++;
        if (g_addr !== 8'hFF) begin bad++; $display("FAIL rom_addr_last got=%h exp=ff", g_addr); end
    endtask

    task automatic test_latch_hold();
        tick(50, 250);
        dino_x_i = 10'd300;
        for (int x = 98; x <= 118; x++) begin
            tick(x, 205);
            total++;
            if (g_rgb !== e_rgb) begin bad++; $display("FAIL hold_old x=%0d got=%h exp=%h", o_x, g_rgb, e_rgb); end
        end
        tick(305, 205);
        tick(0, 10);
        total++;
        if (g_rgb !== 12'hFFF) begin bad++; $display("FAIL hold_not_moved got=%h exp=fff", g_rgb); end
        tick(639, 479);
        tick(0, LY);
        total++;
        if (g_fs !== 1'b1) begin bad++; $display("FAIL latch_pulse got=%b exp=1", g_fs); end
        for (int x = 296; x <= 318; x++) begin
            tick(x, 205);
            total++;
            if (g_rgb !== e_rgb || g_fs !== 1'b0) begin
                bad++; $display("FAIL hold_new x=%0d got=%h/%b exp=%h/0", o_x, g_rgb, g_fs, e_rgb);
            end
        end
        tick(100, 205);
        tick(0, 0);
        total++;
        if (g_rgb !== 12'hFFF) begin bad++; $display("FAIL moved_away got=%h exp=fff", g_rgb); end
    endtask

    task automatic test_obstacle();
        set_rom(0);
        dino_x_i = 10'd632; dino_y_i = 10'd385; obst_x_i = 10'd630;
        tick(0, LY);
        for (int x = 625; x <= 645; x++) begin
            tick(x, 390);
            total++;
            if (g_rgb !== e_rgb) begin bad++; $display("FAIL obst_row x=%0d got=%h exp=%h", o_x, g_rgb, e_rgb); end
        end
        for (int x = 626; x <= 642; x++) begin
            tick(x, 400);
            total++;
            if (g_rgb !== e_rgb) begin bad++; $display("FAIL ground_row x=%0d got=%h exp=%h", o_x, g_rgb, e_rgb); end
        end
        tick(633, 390);
        tick(639, 390);
        total++;
        if (g_rgb !== 12'h0A0) begin bad++; $display("FAIL see_through got=%h exp=0a0", g_rgb); end
        tick(640, 390);
        total++;
        if (g_rgb !== 12'h0A0) begin bad++; $display("FAIL obst_last got=%h exp=0a0", g_rgb); end
        tick(635, 400);
        total++;
        if (g_rgb !== 12'h000) begin bad++; $display("FAIL obst_clip got=%h exp=000", g_rgb); end
        tick(635, 376);
        total++;
        if (g_rgb !== 12'h850) begin bad++; $display("FAIL ground got=%h exp=850", g_rgb); end
        tick(635, 375);
        total++;
        if (g_rgb !== 12'h0A0) begin bad++; $display("FAIL obst_top got=%h exp=0a0", g_rgb); end
        set_rom(1);
        tick(633, 390);
        tick(0, 0);
        total++;
        if (g_rgb !== 12'h333) begin bad++; $display("FAIL dino_over_obst got=%h exp=333", g_rgb); end
    endtask

    task automatic test_random();
        int x, y, r;
        for (int f = 0; f < 5; f++) begin
            set_rom(2);
            dino_x_i = 10'($urandom_range(0, 660));
            dino_y_i = 10'($urandom_range(0, 500));
            obst_x_i = 10'($urandom_range(0, 660));
            tick(0, LY);
            for (int n = 0; n < 200; n++) begin
                r = $urandom_range(0, 3);
                if (r < 2) begin
                    x = sh_dx - 2 + $urandom_range(0, 19);
                    y = sh_dy - 2 + $urandom_range(0, 19);
                end else if (r == 2) begin
                    x = sh_ox - 2 + $urandom_range(0, 15);
                    y = 372 + $urandom_range(0, 31);
                end else begin
                    x = $urandom_range(0, 799);
                    y = $urandom_range(0, 524);
                end
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                if (x > 799) x = 799;
                if (y > 524) y = 524;
                tick(x, y);
                total++;
                if (g_rgb !== e_rgb || g_addr !== e_addr || g_hs !== e_hs || g_vs !== e_vs || g_coll !== e_coll) begin
                    bad++;
                    $display("FAIL random (%0d,%0d) got=%h/%h/%b%b/%b exp=%h/%h/%b%b/%b",
                             o_x, o_y, g_rgb, g_addr, g_hs, g_vs, g_coll, e_rgb, e_addr, e_hs, e_vs, e_coll);
                end
            end
        end
    endtask

    task automatic scan_collision_area(input string tag);
        for (int y = 376; y <= 395; y++) begin
            for (int x = 195; x <= 220; x++) begin
                tick(x, y);
                total++;
                if (g_rgb !== e_rgb || g_coll !== e_coll) begin
                    bad++; $display("FAIL %s (%0d,%0d) got=%h/%b exp=%h/%b", tag, o_x, o_y, g_rgb, g_coll, e_rgb, e_coll);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic exp_hit;
`ifdef VGA_COLLISION_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif
        set_rom(1);
        dino_x_i = 10'd200; dino_y_i = 10'd380; obst_x_i = 10'd205;
        tick(0, LY);
        tick(700, 500);
        tick(700, 500);
        scan_collision_area("coll_frame1");
        dino_x_i = 10'd0;
        tick(700, 500);
        tick(0, LY);
        total++;
        if (g_coll !== exp_hit || g_coll !== e_coll) begin
            bad++; $display("FAIL coll_set got=%b exp=%b", g_coll, exp_hit);
        end
        scan_collision_area("coll_frame2");
        total++;
        if (g_coll !== exp_hit) begin bad++; $display("FAIL coll_hold got=%b exp=%b", g_coll, exp_hit); end
        tick(700, 500);
        tick(0, LY);
        total++;
        if (g_coll !== 1'b0) begin bad++; $display("FAIL coll_clear got=%b exp=0", g_coll); end
        tick(10, 10);
        total++;
        if (g_coll !== 1'b0) begin bad++; $display("FAIL coll_stay_clear got=%b exp=0", g_coll); end
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sync();
        test_dino();
        test_latch_hold();
        test_obstacle();
        test_random();
        test_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sprite_painter.md
Name: vga_sprite_painter

Overview:
- Pixel-colour stage directly downstream of the VGA timer: consumes its hsync/vsync/visible/position outputs and produces 12-bit RGB plus delayed syncs for the VGA pins.
- Draws dino sprite from an external 1-bit sprite ROM, one rectangular obstacle, ground band and sky.
- Game-logic positions are latched once per frame, so the image never tears.

Parameters:
- SPRITE_W, 16, dino sprite width in pixels (power of 2)
- SPRITE_H, 16, dino sprite height in pixels (power of 2)
- OBST_W, 12, obstacle width in pixels
- OBST_H, 24, obstacle height in pixels
- GROUND_Y, 400, first row of ground band; obstacle bottom edge sits at GROUND_Y-1
- LATCH_Y, 480, row on which positions are latched (first non-visible row)

Ports:
- clk_i  in  1  25.175 MHz pixel clock
- rst_i  in  1  asynchronous, active-high reset
- hsync_i  in  1  timer hsync (active low)
- vsync_i  in  1  timer vsync (active low)
- visible_i  in  1  timer visible flag
- position_x_i  in  10  timer column
- position_y_i  in  10  timer row
- dino_x_i  in  10  dino left edge from game logic
- dino_y_i  in  10  dino top edge
- obst_x_i  in  10  obstacle left edge
- rom_addr_o  out  log2(SPRITE_W*SPRITE_H)  sprite ROM address {dy,dx}
- rom_data_i  in  1  ROM pixel, valid 1 cycle after address (1 = opaque)
- vga_red_o  out  4  red
- vga_green_o  out  4  green
- vga_blue_o  out  4  blue
- hsync_o  out  1  hsync delayed to match colour
- vsync_o  out  1  vsync delayed to match colour
- frame_start_o  out  1  1-cycle pulse when positions are latched
- collision_o  out  1  see Optional Feature

Behaviour:
- Reset (async, rst_i=1): colours 0x000, hsync_o=1, vsync_o=1, frame_start_o=0, collision_o=0, latched positions 0, pipeline valid bits 0.
- Latch: when position_x_i==0 && position_y_i==LATCH_Y, register dino_x/dino_y/obst_x into shadow registers next edge. frame_start_o=1 on the following cycle for exactly 1 cycle. Inputs may change at any other time without visible effect.
- Stage 1 (registered):
  - Compute hits with 11-bit unsigned compares (no wrap).
  - dino_hit: px in [dx, dx+SPRITE_W) and py in [dy, dy+SPRITE_H).
  - obst_hit: px in [ox, ox+OBST_W) and py in [GROUND_Y-OBST_H, GROUND_Y).
  - ground: py >= GROUND_Y.
  - rom_addr_o = {(py-dy)[log2 H-1:0], (px-dx)[log2 W-1:0]}, registered; 0 when not dino_hit.
  - Also registered: fallback colour, visible, syncs.
- Stage 2 (registered): colour = dino colour 0x333 if dino_hit && rom_data_i, else fallback.
  - Fallback priority: obstacle 0x0A0 > ground 0x850 > sky 0xFFF.
  - Forced 0x000 when visible is low.
- Latency: exactly 2 cycles from timer inputs to colour/hsync_o/vsync_o. All three are aligned.
- Clipping: a sprite extending past column 639 or row 479 is simply not drawn there (visible=0). Positions ≥ 640 produce no hits.
- Transparent dino pixels (rom_data_i=0) show the lower-priority layer.
- Reset mid-frame: outputs return to reset values immediately. After release, the first valid colour appears 2 cycles later. Shadow positions stay 0 until the next latch row.

Optional Feature:
- Macro: VGA_COLLISION_EN.
- Defined:
  - A sticky flag sets when a pixel has opaque dino and obst_hit simultaneously in stage 2 with visible=1.
  - At frame latch, collision_o takes the flag value and holds it for the whole next frame; the flag then clears.
  - A collision and the latch on the same cycle: that collision counts toward the next frame.
- Undefined: collision_o tied 0, no flag logic.

Test Plan:
- Reset asserted mid-line at x=300 -> colours 0x000, syncs 1 within same cycle; after release with x=10,y=10 -> 0xFFF 2 cycles later.
- Timer at x=656..751 -> hsync_o low for exactly 96 cycles, shifted 2 cycles; y=490,491 -> vsync_o low, shifted 2 cycles.
- dino_x=100, dino_y=200, ROM all-ones, latch frame -> x=100..115 on y=200 gives 0x333; x=99 and x=116 give 0xFFF. rom_addr_o=0x00 at (100,200) and 0xFF at (115,215).
- Change dino_x to 300 at y=250 -> current frame unchanged; frame_start_o pulse at (0,480); next frame draws at 300.
- obst_x=630, y=390 -> x=630..639 green, nothing past 639. y=400 -> ground 0x850. Dino over obstacle with ROM=0 -> green shows through.
- VGA_COLLISION_EN: dino at (200,380), obst_x=205, ROM all-ones -> collision_o=1 after next latch for one frame. Move dino to x=0 -> collision_o returns to 0 after the following latch.
